// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (0 highest) instead.
module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              s1,
  output logic              s0,
  output logic [3:0]        gnt,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_n;
  logic [1:0] sel, sel_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] gnt_n;
  logic [3:0] cnt_inc;
  logic [1:0] win;
  logic       found;
  logic       xfer;
  logic       hit;

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = (state == GRANT);

  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign cnt_inc   = cnt + 4'd1;
  assign hit       = (cnt_inc == 4'(HOLD_MAX));
  assign found     = |req;

  always_comb begin
    out_data = d0;
    unique case (sel)
      2'd0: out_data = d0;
      2'd1: out_data = d1;
      2'd2: out_data = d2;
      2'd3: out_data = d3;
    endcase
  end

`ifdef MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] ptr, ptr_n;
  logic [1:0] idx;

  // Scan from farthest to nearest so the entry after ptr wins.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    ptr_n = ptr;
    if (state == IDLE && found) ptr_n = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 2'd3;
    else        ptr <= ptr_n;
  end
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    gnt_n   = gnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          sel_n   = win;
          cnt_n   = 4'd0;
          gnt_n   = 4'b0001 << win;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
        end else if (xfer) begin
          cnt_n = cnt_inc;
          if (last[sel] || hit) begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      cnt   <= 4'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-cycle model compare plus directed literals.
// Honours MUX_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_mux4_rr_arbiter;

  localparam int DW   = 1;
  localparam int HOLD = 4;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [3:0]    req = 0;
  logic [3:0]    last = 0;
  logic [DW-1:0] d0 = 0, d1 = 0, d2 = 0, d3 = 0;
  logic          out_ready = 0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          s1, s0;
  logic [3:0]    gnt;
  logic          busy;

  int nvec = 0;
  int nerr = 0;
  bit fix_d0 = 0;

  mux4_rr_arbiter #(.DATA_W(DW), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .s1(s1), .s0(s0),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: who owns the channel, how many beats so far, who went last.
  int m_own = -1;
  int m_ptr = 3;
  int m_cnt = 0;
  int m_sel = 0;

  function automatic int pick(logic [3:0] r, int p);
    int w;
    w = -1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      if (w < 0 && r[i]) w = i;
`else
    for (int k = 1; k <= 4; k++)
      if (w < 0 && r[(p + k) % 4]) w = (p + k) % 4;
`endif
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_ptr = 3; m_cnt = 0; m_sel = 0;
    end else if (m_own < 0) begin
      if (req != 0) begin
        m_own = pick(req, m_ptr);
        m_sel = m_own; m_ptr = m_own; m_cnt = 0;
      end
    end else if (!req[m_own]) begin
      m_own = -1;
    end else if (out_ready) begin
      m_cnt++;
      if (last[m_own] || m_cnt == HOLD) m_own = -1;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic e_busy, e_valid;
    logic [DW-1:0] e_data;
    e_busy  = (m_own >= 0);
    e_gnt   = e_busy ? (4'b0001 << m_own) : 4'b0000;
    e_valid = e_busy && req[m_sel];
    case (m_sel)
      0: e_data = d0;
      1: e_data = d1;
      2: e_data = d2;
      default: e_data = d3;
    endcase
    nvec++;
    if (gnt !== e_gnt || busy !== e_busy || out_valid !== e_valid ||
        {s1, s0} !== 2'(m_sel) || out_data !== e_data) begin
      nerr++;
      $display("FAIL cycle@%0t: gnt=%b busy=%b v=%b sel=%b data=%h want %b %b %b %b %h",
               $time, gnt, busy, out_valid, {s1, s0}, out_data,
               e_gnt, e_busy, e_valid, 2'(m_sel), e_data);
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      d1 = DW'($urandom);
      d2 = DW'($urandom);
      d3 = DW'($urandom);
      d0 = fix_d0 ? DW'(1) : DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; req = 0; last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic record(int n, output int seq[$], output int runs[$]);
    logic pb;
    int run;
    pb = 0; run = 0;
    seq = {}; runs = {};
    repeat (n) begin
      tick(1);
      if (busy && !pb) seq.push_back(oh2i(gnt));
      if (busy) run++;
      else if (pb) begin runs.push_back(run); run = 0; end
      pb = busy;
    end
  endtask

  initial begin
    int seq[$];
    int runs[$];
    int exp2[5];
    int exp6[4];

    // Two-beat burst from requester 0 closed by last.
    do_reset();
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    fix_d0 = 1; d0 = 1;
    req = 4'b0001; out_ready = 1;
    tick(1);
    chk("t1_gnt", 8'(gnt), 8'h1);
    chk("t1_sel", 8'({s1, s0}), 8'h0);
    chk("t1_data", 8'(out_data), 8'h1);
    tick(1);
    chk("t1_beat1_busy", 8'(busy), 8'h1);
    last = 4'b0001;
    tick(1);
    chk("t1_rel_busy", 8'(busy), 8'h0);
    chk("t1_rel_gnt", 8'(gnt), 8'h0);
    req = 0; last = 0; fix_d0 = 0;
    tick(1);

    // All request: rotation with HOLD beats each and one idle gap.
    do_reset();
    req = 4'b1111; out_ready = 1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp2 = '{0, 0, 0, 0, 0};
`else
    exp2 = '{0, 1, 2, 3, 0};
`endif
    record(25, seq, runs);
    chk("t2_ngrants", 8'(seq.size()), 8'd5);
    chk("t2_nruns", 8'(runs.size()), 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < seq.size()) chk($sformatf("t2_owner%0d", i), 8'(seq[i]), 8'(exp2[i]));
      if (i < runs.size()) chk($sformatf("t2_len%0d", i), 8'(runs[i]), 8'(HOLD));
    end
    req = 0;

    // Stall requester 2 for five cycles, then drain.
    do_reset();
    req = 4'b0100; out_ready = 0;
    tick(1);
    chk("t3_gnt", 8'(gnt), 8'h4);
    chk("t3_sel", 8'({s1, s0}), 8'h2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t3_stall_gnt", 8'(gnt), 8'h4);
      chk("t3_stall_valid", 8'(out_valid), 8'h1);
    end
    out_ready = 1;
    tick(3);
    chk("t3_beat3_busy", 8'(busy), 8'h1);
    tick(1);
    chk("t3_beat4_busy", 8'(busy), 8'h0);
    req = 0;

    // Requester 1 withdraws after one beat; 2 goes next.
    do_reset();
    req = 4'b0010; out_ready = 1;
    tick(1);
    chk("t4_gnt1", 8'(gnt), 8'h2);
    tick(1);
    req = 4'b0100;
    tick(1);
    chk("t4_rel_busy", 8'(busy), 8'h0);
    req = 4'b0110;
    tick(1);
`ifdef MUX_ARB_FIXED_PRIO_EN
    chk("t4_next", 8'(gnt), 8'h2);
`else
    chk("t4_next", 8'(gnt), 8'h4);
`endif
    req = 0;

    // Asynchronous reset in the middle of a burst from requester 3.
    do_reset();
    req = 4'b1000; out_ready = 1;
    tick(2);
    chk("t5_pre_gnt", 8'(gnt), 8'h8);
    rst_n = 0;
    #1;
    chk("t5_gnt", 8'(gnt), 8'h0);
    chk("t5_sel", 8'({s1, s0}), 8'h0);
    chk("t5_busy", 8'(busy), 8'h0);
    chk("t5_valid", 8'(out_valid), 8'h0);
    @(posedge clk);
    #2 rst_n = 1;
    req = 4'b1111;
    tick(1);
    chk("t5_after", 8'(gnt), 8'h1);
    req = 0;

    // Two requesters held: alternate, or 1 forever with fixed priority.
    do_reset();
    req = 4'b1010; out_ready = 1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp6 = '{1, 1, 1, 1};
`else
    exp6 = '{1, 3, 1, 3};
`endif
    record(20, seq, runs);
    chk("t6_ngrants", 8'(seq.size()), 8'd4);
    for (int i = 0; i < 4; i++)
      if (i < seq.size()) chk($sformatf("t6_owner%0d", i), 8'(seq[i]), 8'(exp6[i]));
    req = 0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
